// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier, one multiplier bit per clock
// Optional: MULTIPLIER_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 last_iter;

    // Accumulator value after the current iteration; also what Out captures on the last one.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MULTIPLIER_EARLY_EXIT_EN
    assign last_iter = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = Start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands load in IDLE and DONE alike so back-to-back Starts need no idle gap.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Out    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_iter) begin
                Out <= acc_sum;
            end
        end else if (Start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [63:0] Out;

    int total = 0;
    int bad   = 0;

    shift_add_multiplier #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Out   (Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycles from the accepting edge to the edge that enters DONE.
    function automatic int exp_latency(input logic [31:0] b);
`ifdef MULTIPLIER_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) hi = i + 1;
        end
        return (hi < 1) ? 1 : hi;
`else
        return 32;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        int          n;
        int          both;
        exp  = 64'(a) * 64'(b);
        lat  = exp_latency(b);
        n    = 0;
        both = 0;
        @(negedge CLK);
        Start = 1'b1;
        A     = a;
        B     = b;
        @(negedge CLK);
        Start = 1'b0;
        while (!Done && n < 100) begin
            if (Busy) n++;
            A = $urandom;
            B = $urandom;
            @(negedge CLK);
            if (Busy && Done) both++;
        end
        check({tag, "_done"}, 64'(Done), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_out"}, Out, exp);
        check({tag, "_busy_done_excl"}, 64'(both), 64'd0);
        @(negedge CLK);
        check({tag, "_done_pulse"}, 64'(Done), 64'd0);
        check({tag, "_out_hold"}, Out, exp);
    endtask

    initial begin
        int          stray;
        int          ops;
        int          done_at;
        int          next_acc;
        logic [63:0] pend_exp;

        Reset = 1'b0;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_out", Out, 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge CLK);
            if (Done || Busy) stray++;
        end
        check("idle_after_reset", 64'(stray), 64'd0);

        run_op("small", 32'd7, 32'd6);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("msb_x2", 32'h8000_0000, 32'd2);
        run_op("b_one", 32'h0000_1234, 32'd1);
        run_op("b_zero", $urandom, 32'd0);
        run_op("b_bit16", $urandom, 32'h0001_0000);
        for (int i = 0; i < 8; i++) begin
            run_op("rand", $urandom, $urandom);
        end

        // Start held high with operands changing every cycle.
        stray    = 0;
        ops      = 0;
        done_at  = -10;
        next_acc = 0;
        pend_exp = '0;
        Start    = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (k - 1 == done_at) begin
                check("b2b_done", 64'(Done), 64'd1);
                check("b2b_out", Out, pend_exp);
                ops++;
                if (ops == 4) break;
            end else if (Done) begin
                stray++;
            end
            A = $urandom;
            B = $urandom;
            if (k == next_acc) begin
                pend_exp = 64'(A) * 64'(B);
                done_at  = k + exp_latency(B);
                next_acc = done_at + 1;
            end
            @(negedge CLK);
        end
        Start = 1'b0;
        check("b2b_ops", 64'(ops), 64'd4);
        check("b2b_stray_done", 64'(stray), 64'd0);
        @(negedge CLK);
        @(negedge CLK);

        // Reset in the middle of a run aborts it.
        Start = 1'b1;
        A     = 32'd12345;
        B     = 32'd6789;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        #2;
        Reset = 1'b0;
        #1;
        check("midreset_busy", 64'(Busy), 64'd0);
        check("midreset_done", 64'(Done), 64'd0);
        check("midreset_out", Out, 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done) stray++;
        end
        check("midreset_no_done", 64'(stray), 64'd0);
        check("midreset_out_after", Out, 64'd0);
        run_op("after_reset", 32'd12345, 32'd6789);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned multiplier for the gate-level ALU: forms a 2·WIDTH-bit product of A and B by iterated shift-and-add, one multiplier bit per clock. It is the inverse operation of the ALU's repeated-subtraction divider and is the multiply half of the ALU's MULT/DIV datapath. Results use the same 64-bit Out bus the divider drives. A Start/Busy/Done handshake lets the ALU controller stall on it.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits.
- CLK  input  1  single system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- Start  input  1  request; sampled on rising CLK while not Busy.
- A  input  WIDTH  multiplicand, unsigned; sampled with Start.
- B  input  WIDTH  multiplier, unsigned; sampled with Start.
- Busy  output  1  high while an operation is in progress (state RUN).
- Done  output  1  one-cycle pulse: Out holds a fresh result.
- Out  output  2·WIDTH  product; holds last completed result until the next completion.

## Operation
- Internal registers:
  - MCAND: 2·WIDTH bits, A zero-extended.
  - MPLIER: WIDTH bits.
  - ACC: 2·WIDTH bits.
  - CNT: log2(WIDTH)+1 bits.
  - State register.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 → load MCAND←{0,A}, MPLIER←B, ACC←0, CNT←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If MPLIER[0]: ACC←ACC+MCAND (2·WIDTH-bit add, no carry out possible).
  - MCAND←MCAND<<1, MPLIER←MPLIER>>1, CNT←CNT+1.
  - When CNT reaches WIDTH−1 on this cycle (the last iteration): Out←final ACC value, go to DONE.
- DONE, one cycle:
  - Done=1.
  - Start=1 here is accepted exactly as in IDLE and goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Start while Busy is ignored; the operation in flight and its operands are unaffected.
- A and B are don't-care except on the edge that accepts Start.
- Out changes only on the edge entering DONE. Intermediate ACC values are never visible on Out.
- Arithmetic: unsigned, exact; maximum product (2^WIDTH−1)^2 fits in 2·WIDTH bits.

## Timing
- Reset (Reset=0, asynchronous): state=IDLE, Busy=0, Done=0, Out=0, and ACC, MCAND, MPLIER, CNT cleared. Reset is released synchronously to CLK by the system.
- Reset mid-operation: the operation is aborted, no Done is produced, and Out=0.
- Latency: Start is accepted at edge E0. Busy=1 from E0 through edge E0+WIDTH. Done=1 and Out valid for the cycle after edge E0+WIDTH; with WIDTH=32 that is 32 cycles.
- Throughput: one result per WIDTH+1 cycles with Start held high continuously.
- Done is never asserted for more than one consecutive cycle per operation.
- Busy and Done are never high simultaneously.

## Configuration
- MULTIPLIER_EARLY_EXIT_EN defined:
  - RUN also terminates after any iteration in which the shifted MPLIER becomes 0. Out←ACC, go to DONE.
  - Latency = max(1, position of the highest set bit of B + 1) cycles from the accepting edge to DONE.
  - B=0 gives 1 RUN cycle.
  - Out value is identical to the non-early-exit result.
- Not defined: fixed WIDTH-cycle RUN regardless of operands; no zero-detect logic is built.

## Test plan
- Reset=0 asserted asynchronously between edges → Busy=0, Done=0, Out=0 immediately. After release, the block idles with no Done.
- A=7, B=6, Start 1 cycle → Busy for 32 cycles, then Done pulse with Out=0x000000000000002A. Out stays 0x2A afterwards.
- A=B=0xFFFFFFFF → Out=0xFFFFFFFE00000001 after 32 cycles. Then A=0x80000000, B=2 → Out=0x0000000100000000.
- Start held high with changing A/B during Busy → operands changed mid-run are ignored. Each accepted operation gives Done at the edge-count predicted by the Timing rules, and back-to-back results arrive every 33 cycles.
- Reset pulsed low at RUN cycle 10 of 12345×6789 → no Done, Out=0. A new Start after release gives Out=83810205.
- With MULTIPLIER_EARLY_EXIT_EN:
  - B=1, A=0x1234 → Done after 1 RUN cycle, Out=0x1234.
  - B=0 → Done after 1 cycle, Out=0.
  - B=0x00010000 → Done after 17 cycles.
  - Without the macro, each of these cases takes 32 cycles.
